aes_inv_cipher_ctrl: RTL and testbench
======================================

# aes_inv_cipher_ctrl

Iterative AES-128 decryption sequencer. Accepts one 128-bit ciphertext block, runs the initial AddRoundKey and ten inverse rounds through a single shared inverse_sub_bytes instance, and returns the plaintext. Round keys come from an external key store addressed by round number. It sits between the block-level decrypt interface and the inverse datapath primitives (InvShiftRows, inverse_sub_bytes, AddRoundKey, InvMixColumns).

## Interface
Parameters: none. AES-128 only; Nr = 10 is fixed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to decrypt din; sampled only when ready=1
- din  in  128  ciphertext, byte 0 in [127:120]
- ready  out  1  high in IDLE only
- rk_addr  out  4  round-key index requested (0..10)
- rk_data  in  128  round key for rk_addr, combinational, valid in the same cycle
- dout  out  128  plaintext, valid when done=1, held until the next accepted start
- done  out  1  one-cycle pulse when dout is updated

## Operation
- Internal state: st[127:0], rnd[3:0], FSM state.
- FSM states: IDLE, ROUND, SUB (SUB exists only with AES_INV_SBOX_PIPE_EN), FIN.
- IDLE:
  - rk_addr=10.
  - On start: st <= din ^ rk_data, rnd <= 9, go to ROUND.
- ROUND, rnd = 9..1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data), rnd <= rnd-1.
- ROUND, rnd = 0: st <= InvSubBytes(InvShiftRows(st)) ^ rk_data, with no InvMixColumns; go to FIN.
- FIN: dout <= st, done=1 for this cycle, go to IDLE.
- rk_addr = rnd in every non-IDLE state.
- start while ready=0 is ignored. It is not queued.
- start asserted in the FIN cycle is ignored. It is accepted from the following IDLE cycle.
- Exactly one inverse_sub_bytes instance exists. Its input is InvShiftRows(st).

## Timing
- Reset values, applied asynchronously: FSM=IDLE, st=0, rnd=0, dout=0, done=0, ready=1, rk_addr=10.
- rst asserted mid-operation: the block aborts immediately. No done is issued and dout returns to 0.
- Without the macro, counting the start-sampling edge as edge 0:
  - ROUND updates occur on edges 1..10.
  - done is high for the cycle following edge 10, the FIN cycle.
  - ready returns after edge 11.
  - Start-to-done latency is 11 cycles.
  - Throughput is one block per 12 cycles.
- With the macro: each round takes 2 cycles (ROUND then SUB), so done follows edge 20 (21-cycle latency).
- done is never high for two consecutive cycles.
- dout changes only on the FIN edge and on reset.

## Configuration
- AES_INV_SBOX_PIPE_EN defined:
  - A 128-bit register captures the inverse_sub_bytes output in ROUND. rk_addr=rnd is held.
  - SUB applies the AddRoundKey and, for rnd≠0, InvMixColumns to the registered value, writes st, then decrements rnd or goes to FIN.
  - This cuts the S-box-to-MixColumns critical path.
- Undefined: single-cycle rounds as described above. The SUB state and its register are absent.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, din=3925841d02dc09fbdc118597196a0b32 -> done exactly 11 cycles after start (21 with macro), dout=3243f6a8885a308d313198a2e0370734.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f (rk10=13111d7fe3944a17f307a78b4d2b30c5), din=69c4e0d86a7b0430d8cdb78070b4c55a -> dout=00112233445566778899aabbccddeeff.
- rk_addr trace: rk_addr observed per cycle after start must be 10, 9, 8, …, 0, with each value held 2 cycles when the macro is defined.
- start held high continuously with the App. B vector -> one done per 12 cycles (22 with macro), each dout correct, ready low between.
- rst pulsed on the 5th cycle after start -> dout=0, done stays 0, ready=1 immediately. A fresh start then gives the correct App. C.1 result.
- After reset with no start for 50 cycles -> done=0, dout=0, rk_addr=10.

Source files
------------

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES-128 decryption sequencer.
// One ciphertext block is decrypted as an initial AddRoundKey followed by ten
// inverse rounds, all sharing a single inverse_sub_bytes instance. Round keys
// are fetched from an external key store through rk_addr_o / rk_data_i.
// Optional build macro: AES_INV_SBOX_PIPE_EN registers the S-box output so that
// each round takes two cycles (ROUND then SUB).

// Byte-parallel inverse S-box over a 128-bit state (16 lookups).
module inverse_sub_bytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);
    // Inverse S-box table, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[8*(255 - int'(x)) +: 8];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign data_o[8*gi +: 8] = inv_sbox(data_i[8*gi +: 8]);
        end
    endgenerate
endmodule

module aes_inv_cipher_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] din_i,
    output logic         ready_o,
    output logic [3:0]   rk_addr_o,
    input  logic [127:0] rk_data_i,
    output logic [127:0] dout_o,
    output logic         done_o
);
`ifdef AES_INV_SBOX_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, SUB = 2'd2, FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FIN = 2'd3} state_t;
`endif

    localparam logic [3:0] LAST_KEY = 4'd10;

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] dout_q, dout_d;
    logic [127:0] isr_out;
    logic [127:0] isb_out;

    // GF(2^8) multiply by x modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Byte b sits at [127-8b -: 8]; row = b%4, column = b/4. Row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
                                   mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
                                   mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
                                   mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
        end
        return r;
    endfunction

    // The one shared S-box bank always sees InvShiftRows of the current state.
    assign isr_out = inv_shift_rows(st_q);

    inverse_sub_bytes u_isb (
        .data_i (isr_out),
        .data_o (isb_out)
    );

`ifdef AES_INV_SBOX_PIPE_EN
    logic [127:0] sub_q, sub_d;
    logic [127:0] ark;

    // AddRoundKey on the registered S-box output; rk_addr is unchanged across ROUND/SUB.
    assign ark = sub_q ^ rk_data_i;

    // Pipeline register between the S-box bank and InvMixColumns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= '0;
        end else begin
            sub_q <= sub_d;
        end
    end
`else
    logic [127:0] ark;

    assign ark = isb_out ^ rk_data_i;
`endif

    // State, round counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state and datapath sequencing. dout is loaded with the final round
    // result as FIN is entered, so it is already valid while done is high.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
`ifdef AES_INV_SBOX_PIPE_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    st_d    = din_i ^ rk_data_i;
                    rnd_d   = 4'd9;
                    state_d = ROUND;
                end
            end
`ifdef AES_INV_SBOX_PIPE_EN
            ROUND: begin
                sub_d   = isb_out;
                state_d = SUB;
            end
            SUB: begin
                if (rnd_q == 4'd0) begin
                    st_d    = ark;
                    dout_d  = ark;
                    state_d = FIN;
                end else begin
                    st_d    = inv_mix_columns(ark);
                    rnd_d   = rnd_q - 4'd1;
                    state_d = ROUND;
                end
            end
`else
            ROUND: begin
                if (rnd_q == 4'd0) begin
                    st_d    = ark;
                    dout_d  = ark;
                    state_d = FIN;
                end else begin
                    st_d    = inv_mix_columns(ark);
                    rnd_d   = rnd_q - 4'd1;
                end
            end
`endif
            FIN: begin
                // A start seen here is dropped; the next IDLE cycle can accept one.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o   = (state_q == IDLE);
    assign rk_addr_o = (state_q == IDLE) ? LAST_KEY : rnd_q;
    assign done_o    = (state_q == FIN);
    assign dout_o    = dout_q;
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed testbench for aes_inv_cipher_ctrl: FIPS-197 vectors, rk_addr trace,
// back-to-back starts, mid-operation reset and idle behaviour.
// Honours AES_INV_SBOX_PIPE_EN for the expected round timing.
module tb_aes_inv_cipher_ctrl;
`ifdef AES_INV_SBOX_PIPE_EN
    localparam int LAT  = 20;
    localparam int STEP = 2;
`else
    localparam int LAT  = 10;
    localparam int STEP = 1;
`endif
    localparam int PERIOD = LAT + 2;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    // Forward S-box, used only by the bench's key expansion.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] din;
    logic         ready;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic [127:0] dout;
    logic         done;

    logic [127:0] rk_mem [0:15];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    // Key store: combinational read addressed by the DUT.
    assign rk_data = rk_mem[rk_addr];

    aes_inv_cipher_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .din_i     (din),
        .ready_o   (ready),
        .rk_addr_o (rk_addr),
        .rk_data_i (rk_data),
        .dout_o    (dout),
        .done_o    (done)
    );

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[8*(255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One block from IDLE: checks latency, rk_addr trace, dout hold and done pulse.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                             input logic [127:0] pt, input logic [127:0] prev);
        int e;
        expand_key(key);
        @(negedge clk);
        din   = ct;
        start = 1'b1;
        chk({tag, "_ready_start"}, 128'(ready), 128'(1'b1));
        chk({tag, "_rk_start"}, 128'(rk_addr), 128'(4'd10));
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            e = (k < LAT) ? (9 - k / STEP) : 0;
            chk($sformatf("%s_done_e%0d", tag, k), 128'(done), 128'(k == LAT));
            if (k <= LAT) begin
                chk($sformatf("%s_rk_e%0d", tag, k), 128'(rk_addr), 128'(e));
                chk($sformatf("%s_ready_e%0d", tag, k), 128'(ready), 128'(1'b0));
            end
            if (k == LAT - 1) chk({tag, "_dout_hold"}, dout, prev);
            if (k == LAT) chk({tag, "_dout"}, dout, pt);
            if (k == LAT + 1) begin
                chk({tag, "_ready_back"}, 128'(ready), 128'(1'b1));
                chk({tag, "_dout_kept"}, dout, pt);
            end
        end
        $display("block %s: ct=%h dout=%h", tag, ct, dout);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1'b1));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_dout", dout, 128'h0);
        chk("rst_rk", 128'(rk_addr), 128'(4'd10));
        rst = 1'b0;
        $display("reset released");

        // Idle for 50 cycles with no start
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk($sformatf("idle_done_%0d", i), 128'(done), 128'(1'b0));
        end
        chk("idle_dout", dout, 128'h0);
        chk("idle_rk", 128'(rk_addr), 128'(4'd10));
        $display("idle 50 cycles: done=%0b dout=%h rk_addr=%0d", done, dout, rk_addr);

        // FIPS-197 vectors
        run_block("appB", KEY_B, CT_B, PT_B, 128'h0);
        run_block("appC", KEY_C, CT_C, PT_C, PT_B);

        // start held high: one block per PERIOD cycles
        expand_key(KEY_B);
        @(negedge clk);
        din   = CT_B;
        start = 1'b1;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk);
            chk($sformatf("strm_done_%0d", k), 128'(done), 128'((k % PERIOD) == LAT));
            chk($sformatf("strm_ready_%0d", k), 128'(ready), 128'((k % PERIOD) == LAT + 1));
            if ((k % PERIOD) == LAT) begin
                chk($sformatf("strm_dout_%0d", k), dout, PT_B);
                $display("stream done at edge %0d: dout=%h", k, dout);
            end
        end
        start = 1'b0;

        // Reset in the middle of a block
        expand_key(KEY_C);
        @(negedge clk);
        din   = CT_C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", 128'(ready), 128'(1'b1));
        chk("abort_done", 128'(done), 128'(1'b0));
        chk("abort_dout", dout, 128'h0);
        chk("abort_rk", 128'(rk_addr), 128'(4'd10));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_nodone_%0d", i), 128'(done), 128'(1'b0));
        end
        $display("abort: dout=%h ready=%0b", dout, ready);
        run_block("appC_after_abort", KEY_C, CT_C, PT_C, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
